// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel/colour logic.
// master drives the timing outputs; slave consumes them.
interface vga_timing_gen_if #(
  parameter int CNT_W = 11
) ();
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             de;
  logic             hs;
  logic             vs;
  logic             pix_ce;
  logic             line_start;
  logic             frame_start;
  logic [15:0]      frame_cnt;

  modport master (
    output x, y, de, hs, vs, pix_ce, line_start, frame_start, frame_cnt
  );

  modport slave (
    input x, y, de, hs, vs, pix_ce, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VESA-style raster timing generator (clock divider, x/y counters, syncs, DE, markers).
// Define VGA_TIMING_FRAME_CNT_EN to build the frame counter; otherwise frame_cnt is tied to zero.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 1,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Region bounds are one bit wider so a total of exactly 2^CNT_W still compares correctly.
  localparam logic [CNT_W:0] H_ACT_END = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] HS_BEGIN  = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] HS_END    = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_ACT_END = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] VS_BEGIN  = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] VS_END    = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0]       div_q, div_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             de_q, de_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             pix_ce_q;
  logic             line_start_q;
  logic             frame_start_q;
  logic             tick;
  logic             x_wrap;
  logic             y_wrap;
  logic [CNT_W:0]   x_ext;
  logic [CNT_W:0]   y_ext;

  always_comb begin
    div_d  = div_q;
    tick   = 1'b0;
    if (en) begin
      if (div_q == DIV_LAST) begin
        tick  = 1'b1;
        div_d = '0;
      end else begin
        div_d = div_q + 4'd1;
      end
    end

    x_wrap = (x_q == H_LAST);
    y_wrap = (y_q == V_LAST);

    x_d = x_wrap ? '0 : x_q + CNT_W'(1);
    y_d = y_q;
    if (x_wrap) begin
      y_d = y_wrap ? '0 : y_q + CNT_W'(1);
    end

    // Decode from the next position so the flags land on the same edge as x/y.
    x_ext = {1'b0, x_d};
    y_ext = {1'b0, y_d};
    de_d  = (x_ext < H_ACT_END) && (y_ext < V_ACT_END);
    hs_d  = ((x_ext >= HS_BEGIN) && (x_ext < HS_END)) ? HS_POL : ~HS_POL;
    vs_d  = ((y_ext >= VS_BEGIN) && (y_ext < VS_END)) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      de_q          <= 1'b0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      pix_ce_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_ce_q      <= tick;
      line_start_q  <= tick && x_wrap;
      frame_start_q <= tick && x_wrap && y_wrap;
      if (tick) begin
        x_q  <= x_d;
        y_q  <= y_d;
        de_q <= de_d;
        hs_q <= hs_d;
        vs_q <= vs_d;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic        frame_seen_q;

  // The (0,0) tick straight out of reset opens the first frame rather than completing one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q  <= '0;
      frame_seen_q <= 1'b0;
    end else if (tick && x_wrap && y_wrap) begin
      frame_seen_q <= 1'b1;
      if (frame_seen_q) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`else
  assign vga.frame_cnt = 16'h0;
`endif

  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.de          = de_q;
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.pix_ce      = pix_ce_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule
